// File: rtl/alu_cmd_sequencer.sv
// Command sequencer driving the ALU operand/result interface: one command in, one response out.
// Optional irq event counter built only when ALU_SEQ_IRQ_CNT_EN is defined.
module alu_cmd_sequencer #(
    parameter int HOLD_CYCLES = 2
`ifdef ALU_SEQ_IRQ_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic             alu_clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sel,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_clr,
    output logic             alu_enable,
    output logic             alu_enable_a,
    output logic             alu_enable_b,
    output logic [1:0]       alu_op_a,
    output logic [1:0]       alu_op_b,
    output logic [7:0]       alu_in_a,
    output logic [7:0]       alu_in_b,
    output logic             alu_irq_clr,
    input  logic [7:0]       alu_out,
    input  logic             alu_irq,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_irq,
`ifdef ALU_SEQ_IRQ_CNT_EN
    input  logic             irq_cnt_clr,
    output logic [CNT_W-1:0] irq_count,
`endif
    output logic             busy
);

    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] hold_cnt;
    logic          sel_q, clr_q;
    logic [1:0]    op_q;
    logic [7:0]    a_q, b_q;
    logic          accept;

    assign accept = cmd_valid && cmd_ready;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        cmd_ready    = 1'b0;
        alu_enable   = 1'b0;
        alu_enable_a = 1'b0;
        alu_enable_b = 1'b0;
        alu_irq_clr  = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) state_nxt = EXEC;
            end
            EXEC: begin
                alu_enable   = 1'b1;
                alu_enable_a = ~sel_q;
                alu_enable_b = sel_q;
                alu_irq_clr  = clr_q;
                if (hold_cnt == '0) state_nxt = CAPT;
            end
            CAPT: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (accept)
            hold_cnt <= CW'(HOLD_CYCLES - 1);
        else if (state == EXEC && hold_cnt != '0)
            hold_cnt <= hold_cnt - CW'(1);
    end

    // NOTE: command and response registers are plain flops, reset so all outputs start at 0.
    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            clr_q    <= 1'b0;
            rsp_data <= '0;
            rsp_irq  <= 1'b0;
        end else begin
            if (accept) begin
                sel_q <= cmd_sel;
                op_q  <= cmd_op;
                a_q   <= cmd_a;
                b_q   <= cmd_b;
                clr_q <= cmd_clr;
            end
            if (state == CAPT) begin
                rsp_data <= alu_out;
                rsp_irq  <= alu_irq;
            end
        end
    end

    // Operand and op buses hold the last command after EXEC ends.
    assign alu_in_a = a_q;
    assign alu_in_b = b_q;
    assign alu_op_a = sel_q ? 2'b00 : op_q;
    assign alu_op_b = sel_q ? op_q : 2'b00;

`ifdef ALU_SEQ_IRQ_CNT_EN
    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n)
            irq_count <= '0;
        else if (irq_cnt_clr)
            irq_count <= '0;
        else if (state == CAPT && alu_irq && irq_count != '1)
            irq_count <= irq_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small two-stage ALU model on the far side.
// Define ALU_SEQ_IRQ_CNT_EN to also exercise the irq counter (CNT_W=2).
module tb_alu_cmd_sequencer;

    logic       alu_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_sel = 1'b0, cmd_clr = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic       cmd_ready;
    logic       alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr;
    logic [1:0] alu_op_a, alu_op_b;
    logic [7:0] alu_in_a, alu_in_b;
    logic [7:0] alu_out;
    logic       alu_irq;
    logic       rsp_valid, rsp_irq, busy;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
`ifdef ALU_SEQ_IRQ_CNT_EN
    logic       irq_cnt_clr = 1'b0;
    logic [1:0] irq_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 alu_clk = ~alu_clk;

`ifdef ALU_SEQ_IRQ_CNT_EN
    alu_cmd_sequencer #(.HOLD_CYCLES(2), .CNT_W(2)) dut (
`else
    alu_cmd_sequencer #(.HOLD_CYCLES(2)) dut (
`endif
        .alu_clk(alu_clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_clr(cmd_clr),
        .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_irq_clr(alu_irq_clr), .alu_out(alu_out), .alu_irq(alu_irq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_irq(rsp_irq),
`ifdef ALU_SEQ_IRQ_CNT_EN
        .irq_cnt_clr(irq_cnt_clr), .irq_count(irq_count),
`endif
        .busy(busy)
    );

    // ALU model: two enabled edges to produce a result; irq = result nonzero unless cleared.
    // Group A: 00 AND, 01 ADD, 10 OR, 11 XOR.  Group B: 00 ADD, 01 SUB, 10 AND, 11 OR.
    logic [7:0] st1, st2;
    logic       irq2;
    logic [7:0] f;
    always_comb begin
        f = 8'h00;
        if (alu_enable_a) begin
            case (alu_op_a)
                2'b00: f = alu_in_a & alu_in_b;
                2'b01: f = alu_in_a + alu_in_b;
                2'b10: f = alu_in_a | alu_in_b;
                default: f = alu_in_a ^ alu_in_b;
            endcase
        end else if (alu_enable_b) begin
            case (alu_op_b)
                2'b00: f = alu_in_a + alu_in_b;
                2'b01: f = alu_in_a - alu_in_b;
                2'b10: f = alu_in_a & alu_in_b;
                default: f = alu_in_a | alu_in_b;
            endcase
        end
    end
    always @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            st1 <= '0; st2 <= '0; irq2 <= 1'b0;
        end else if (alu_enable && (alu_enable_a || alu_enable_b)) begin
            st1  <= f;
            st2  <= st1;
            irq2 <= (st1 != 8'h00) && !alu_irq_clr;
        end
    end
    assign alu_out = st2;
    assign alu_irq = irq2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge alu_clk);
        #1;
    endtask

    // Issue one command and follow it through EXEC/CAPT/RESP with exact-latency checks.
    task automatic run_cmd(input string tag, input logic sel, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic clr,
                           input logic [7:0] exp_data, input logic exp_irq);
        check({tag, ".ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_sel = sel; cmd_op = op; cmd_a = a; cmd_b = b; cmd_clr = clr;
        step();
        cmd_valid = 1'b0; cmd_a = ~a; cmd_op = ~op;
        for (int c = 0; c < 2; c++) begin
            check({tag, ".en"},   {alu_enable, alu_enable_a, alu_enable_b}, {1'b1, ~sel, sel});
            check({tag, ".op"},   {alu_op_a, alu_op_b}, sel ? {2'b00, op} : {op, 2'b00});
            check({tag, ".in"},   {alu_in_a, alu_in_b, alu_irq_clr}, {a, b, clr});
            check({tag, ".busy"}, {busy, cmd_ready, rsp_valid}, 3'b100);
            step();
        end
        check({tag, ".capt"}, {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, rsp_valid}, 5'b0);
        step();
        check({tag, ".rspv"}, rsp_valid, 1'b1);
        check({tag, ".data"}, {rsp_data, rsp_irq}, {exp_data, exp_irq});
        check({tag, ".hold"}, {alu_in_a, alu_in_b}, {a, b});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, ".idle"}, {rsp_valid, cmd_ready, busy}, 3'b010);
    endtask

    initial begin
        #12;
        check("rst.en",  {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}, 4'b0);
        check("rst.bus", {alu_op_a, alu_op_b, alu_in_a, alu_in_b}, 20'h0);
        check("rst.rsp", {rsp_valid, rsp_data, rsp_irq, busy}, 11'h0);
        @(negedge alu_clk);
        rst_n = 1'b1;
        #1;
        check("rst.ready", cmd_ready, 1'b1);
        step();

        // rsp_ready with nothing pending is ignored
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("idle.rspready", {busy, rsp_valid, cmd_ready}, 3'b001);

        run_cmd("T1", 1'b0, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b1);
        run_cmd("T2", 1'b1, 2'b11, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b1);
        run_cmd("T3a", 1'b0, 2'b11, 8'h55, 8'h55, 1'b0, 8'h00, 1'b0);
        run_cmd("T3b", 1'b0, 2'b10, 8'hF0, 8'h08, 1'b0, 8'hF8, 1'b1);
        run_cmd("CLR", 1'b0, 2'b10, 8'h0F, 8'h30, 1'b1, 8'h3F, 1'b0);
        run_cmd("ADDB", 1'b1, 2'b00, 8'h80, 8'h80, 1'b0, 8'h00, 1'b0);
        run_cmd("SUBB", 1'b1, 2'b01, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);

        // T4: response back-pressure; a competing command must not be taken
        cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_op = 2'b01; cmd_a = 8'h12; cmd_b = 8'h34; cmd_clr = 1'b0;
        step();
        cmd_valid = 1'b0;
        step(); step(); step();
        cmd_valid = 1'b1; cmd_a = 8'hAA; cmd_op = 2'b00;
        for (int i = 0; i < 5; i++) begin
            check("T4.hold", {rsp_valid, cmd_ready, rsp_data, rsp_irq}, {1'b1, 1'b0, 8'h46, 1'b1});
            check("T4.bus", alu_in_a, 8'h12);
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("T4.done", {rsp_valid, cmd_ready}, 2'b01);

        // T5: async reset in the second EXEC cycle
        cmd_valid = 1'b1; cmd_sel = 1'b1; cmd_op = 2'b10; cmd_a = 8'h3C; cmd_b = 8'h0F; cmd_clr = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        check("T5.exec2", {alu_enable, alu_enable_b, alu_irq_clr}, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        check("T5.en", {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}, 4'b0);
        check("T5.out", {alu_in_a, alu_in_b, alu_op_a, alu_op_b, rsp_valid, busy}, 22'h0);
        @(negedge alu_clk);
        rst_n = 1'b1;
        #1;
        check("T5.ready", {cmd_ready, busy}, 2'b10);
        step();
        run_cmd("T5.after", 1'b1, 2'b10, 8'h3C, 8'h0F, 1'b0, 8'h0C, 1'b1);

`ifdef ALU_SEQ_IRQ_CNT_EN
        // T6: saturation at 3 with CNT_W=2, then clear; clear wins over a coincident increment
        irq_cnt_clr = 1'b1;
        step();
        irq_cnt_clr = 1'b0;
        check("T6.clr0", irq_count, 2'd0);
        for (int i = 0; i < 4; i++)
            run_cmd("T6.cmd", 1'b0, 2'b00, 8'hFF, 8'h0F, 1'b0, 8'h0F, 1'b1);
        check("T6.sat", irq_count, 2'd3);
        irq_cnt_clr = 1'b1;
        run_cmd("T6.win", 1'b0, 2'b00, 8'hFF, 8'h0F, 1'b0, 8'h0F, 1'b1);
        irq_cnt_clr = 1'b0;
        check("T6.clr", irq_count, 2'd0);
        run_cmd("T6.one", 1'b0, 2'b00, 8'hFF, 8'h0F, 1'b0, 8'h0F, 1'b1);
        check("T6.inc", irq_count, 2'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
